// File: rtl/counter_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// counter_ctrl_pkg : shared state encoding and command opcodes
// Rev 1.0
// ============================================================================
package counter_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      RUN   = 3'd2,
      PAUSE = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [1:0] OP_START  = 2'b00;
   localparam logic [1:0] OP_PAUSE  = 2'b01;
   localparam logic [1:0] OP_RESUME = 2'b10;
   localparam logic [1:0] OP_ABORT  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/prescale_tick.sv
`default_nettype none
// ============================================================================
// prescale_tick : tick divider, tick while count equals period; wraps on tick
// Rev 1.0
// ============================================================================
module prescale_tick #(
   parameter int PRESCALE_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  en,
   input  logic [PRESCALE_W-1:0] period,
   output logic                  tick
);

   localparam logic [PRESCALE_W-1:0] c_one = PRESCALE_W'(1);

   logic [PRESCALE_W-1:0] r_cnt;

   assign tick = (r_cnt == period);

   // en low freezes the count so a pause resumes mid-period
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= tick ? '0 : (r_cnt + c_one);
      end
   end

endmodule
`default_nettype wire

// File: rtl/counter_ctrl.sv
`default_nettype none
// ============================================================================
// counter_ctrl : command sequencer driving an external up-counter
// Option macro: AUTO_RELOAD_EN (DONE reloads and repeats instead of holding)
// Rev 1.0
// ============================================================================
module counter_ctrl #(
   parameter int WIDTH      = 8,
   parameter int PRESCALE_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [WIDTH-1:0]      cmd_start,
   input  logic [WIDTH-1:0]      cmd_end,
   input  logic [PRESCALE_W-1:0] cmd_prescale,
   input  logic [WIDTH-1:0]      cnt_q,
   output logic                  cnt_ld,
   output logic [WIDTH-1:0]      cnt_v,
   output logic                  cnt_inc,
   output logic                  busy,
   output logic                  done
);

   import counter_ctrl_pkg::*;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [WIDTH-1:0]      r_start;
   logic [WIDTH-1:0]      r_end;
   logic [PRESCALE_W-1:0] r_prescale;
   logic                  r_busy;
   logic                  r_done;
   logic                  w_busy_nxt;
   logic                  w_acc;
   logic                  w_start;
   logic                  w_pause;
   logic                  w_resume;
   logic                  w_abort;
   logic                  w_term;
   logic                  w_tick;
   logic                  w_pre_en;

   assign cmd_ready = (r_state != LOAD);
   assign w_acc     = cmd_valid && cmd_ready;
   assign w_start   = w_acc && (cmd_op == OP_START);
   assign w_pause   = w_acc && (cmd_op == OP_PAUSE);
   assign w_resume  = w_acc && (cmd_op == OP_RESUME);
   assign w_abort   = w_acc && (cmd_op == OP_ABORT);
   assign w_term    = (cnt_q == r_end);

   always_comb begin
      w_state_nxt = r_state;
      cnt_ld      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_start) w_state_nxt = LOAD;
         end
         LOAD: begin
            cnt_ld      = 1'b1;
            w_state_nxt = RUN;
         end
         RUN: begin
            if (w_abort)      w_state_nxt = IDLE;
            else if (w_start) w_state_nxt = LOAD;
            else if (w_term)  w_state_nxt = DONE;
            else if (w_pause) w_state_nxt = PAUSE;
         end
         PAUSE: begin
            if (w_abort)       w_state_nxt = IDLE;
            else if (w_start)  w_state_nxt = LOAD;
            else if (w_resume) w_state_nxt = RUN;
         end
         DONE: begin
            if (w_abort)      w_state_nxt = IDLE;
            else if (w_start) w_state_nxt = LOAD;
`ifdef AUTO_RELOAD_EN
            else              w_state_nxt = LOAD;
`endif
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // The prescaler only advances on RUN cycles that stay in RUN, so the
   // increment and the prescaler step are suppressed together on any exit.
   assign w_pre_en = (r_state == RUN) && (w_state_nxt == RUN);
   assign cnt_inc  = w_pre_en && w_tick;

`ifdef AUTO_RELOAD_EN
   assign w_busy_nxt = (w_state_nxt != IDLE);
`else
   assign w_busy_nxt = (w_state_nxt == LOAD) || (w_state_nxt == RUN) ||
                       (w_state_nxt == PAUSE);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= (r_state == RUN) && (w_state_nxt == DONE);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_start    <= '0;
         r_end      <= '0;
         r_prescale <= '0;
      end else if (w_start) begin
         r_start    <= cmd_start;
         r_end      <= cmd_end;
         r_prescale <= cmd_prescale;
      end
   end

   prescale_tick #(
      .PRESCALE_W (PRESCALE_W)
   ) u_prescale (
      .clk    (clk),
      .rst    (rst),
      .clr    (cnt_ld),
      .en     (w_pre_en),
      .period (r_prescale),
      .tick   (w_tick)
   );

   assign cnt_v = r_start;
   assign busy  = r_busy;
   assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_counter_ctrl.sv
`default_nettype none
// ============================================================================
// tb_counter_ctrl : directed + randomized checks against a schedule model
// Rev 1.0
// ============================================================================
module tb_counter_ctrl;

   localparam int WIDTH      = 8;
   localparam int PRESCALE_W = 16;

`ifdef AUTO_RELOAD_EN
   localparam bit AUTO_RL = 1'b1;
`else
   localparam bit AUTO_RL = 1'b0;
`endif

   localparam logic [1:0] C_START  = 2'b00;
   localparam logic [1:0] C_PAUSE  = 2'b01;
   localparam logic [1:0] C_RESUME = 2'b10;
   localparam logic [1:0] C_ABORT  = 2'b11;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  cmd_valid = 1'b0;
   logic                  cmd_ready;
   logic [1:0]            cmd_op = 2'b00;
   logic [WIDTH-1:0]      cmd_start = '0;
   logic [WIDTH-1:0]      cmd_end = '0;
   logic [PRESCALE_W-1:0] cmd_prescale = '0;
   logic [WIDTH-1:0]      cnt_q = '0;
   logic                  cnt_ld;
   logic [WIDTH-1:0]      cnt_v;
   logic                  cnt_inc;
   logic                  busy;
   logic                  done;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct packed {
      logic ld;
      logic inc;
      logic dn;
      logic bsy;
      logic rdy;
   } exp_t;

   counter_ctrl #(
      .WIDTH      (WIDTH),
      .PRESCALE_W (PRESCALE_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_start    (cmd_start),
      .cmd_end      (cmd_end),
      .cmd_prescale (cmd_prescale),
      .cnt_q        (cnt_q),
      .cnt_ld       (cnt_ld),
      .cnt_v        (cnt_v),
      .cnt_inc      (cnt_inc),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   // External counter the controller drives
   always @(posedge clk) begin
      if (cnt_ld)       cnt_q <= cnt_v;
      else if (cnt_inc) cnt_q <= cnt_q + WIDTH'(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected outputs `off` cycles after the START-accept edge: one LOAD
   // cycle, n*(p+1) counting cycles, one terminal cycle, then DONE.
   function automatic exp_t expect_at(input int off, input int n, input int p);
      int   len;
      int   ph;
      exp_t e;
      len   = n * (p + 1);
      e     = '0;
      e.rdy = 1'b1;
      ph    = AUTO_RL ? ((off - 1) % (len + 3)) : (off - 1);
      if (ph == 0) begin
         e.ld  = 1'b1;
         e.rdy = 1'b0;
      end
      if (ph >= 1 && ph <= len && ((ph - 1) % (p + 1)) == p) e.inc = 1'b1;
      if (ph == len + 2) e.dn = 1'b1;
      e.bsy = AUTO_RL ? 1'b1 : (ph <= len + 1);
      return e;
   endfunction

   task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] s,
                       input logic [WIDTH-1:0] e, input int p);
      cmd_valid    = 1'b1;
      cmd_op       = op;
      cmd_start    = s;
      cmd_end      = e;
      cmd_prescale = PRESCALE_W'(p);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic go_idle();
      int guard;
      guard = 0;
      @(negedge clk);
      while (!cmd_ready && guard < 4) begin
         @(negedge clk);
         guard++;
      end
      send(C_ABORT, '0, '0, 0);
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
   endtask

   task automatic run_seq(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] e,
                          input int p, input int extra);
      logic [WIDTH-1:0] d;
      int   n;
      int   len;
      int   ph;
      exp_t ex;
      d   = e - s;
      n   = int'(d);
      len = n * (p + 1);
      send(C_START, s, e, p);
      for (int off = 1; off <= len + 3 + extra; off++) begin
         @(negedge clk);
         ex = expect_at(off, n, p);
         chk($sformatf("run s=%0d e=%0d p=%0d off=%0d {ld,inc,done,busy,rdy}", s, e, p, off),
             32'({cnt_ld, cnt_inc, done, busy, cmd_ready}), 32'(ex));
         ph = AUTO_RL ? ((off - 1) % (len + 3)) : (off - 1);
         if (ph == len + 1)
            chk($sformatf("term_cnt_q s=%0d e=%0d off=%0d", s, e, off), 32'(cnt_q), 32'(e));
      end
      chk("cnt_v_holds_start", 32'(cnt_v), 32'(s));
   endtask

   initial begin
      exp_t             ex;
      logic [WIDTH-1:0] rs;
      logic [WIDTH-1:0] re;

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset {ld,inc,done,busy,rdy}", 32'({cnt_ld, cnt_inc, done, busy, cmd_ready}), 32'b00001);
      chk("reset cnt_v", 32'(cnt_v), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Basic, wrap-around, zero-length and auto-reload pattern runs
      run_seq(8'd3, 8'd5, 0, 3);
      go_idle();
      run_seq(8'd254, 8'd1, 1, 3);
      go_idle();
      run_seq(8'd7, 8'd7, 0, 3);
      go_idle();
      run_seq(8'd0, 8'd2, 0, 12);
      go_idle();

      // Randomized runs
      for (int i = 0; i < 8; i++) begin
         rs = WIDTH'($urandom_range(0, 255));
         re = rs + WIDTH'($urandom_range(0, 12));
         run_seq(rs, re, int'($urandom_range(0, 3)), 2);
         go_idle();
      end

      // PAUSE after first tick, hold, RESUME: tick spacing continues
      send(C_START, 8'd10, 8'd30, 2);
      for (int off = 1; off <= 4; off++) begin
         @(negedge clk);
         ex = expect_at(off, 20, 2);
         chk($sformatf("pre_pause off=%0d", off),
             32'({cnt_ld, cnt_inc, done, busy, cmd_ready}), 32'(ex));
      end
      @(posedge clk);
      #1 cmd_valid = 1'b1;
      cmd_op = C_PAUSE;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         chk($sformatf("paused j=%0d {inc,busy,rdy}", j), 32'({cnt_inc, busy, cmd_ready}), 32'b011);
      end
      send(C_RESUME, '0, '0, 0);
      for (int j = 1; j <= 6; j++) begin
         @(negedge clk);
         chk($sformatf("resumed j=%0d inc", j), 32'(cnt_inc), 32'((j % 3) == 0));
      end
      chk("resumed cnt_q", 32'(cnt_q), 32'd12);
      go_idle();

      // ABORT in RUN
      send(C_START, 8'd3, 8'd9, 2);
      repeat (5) @(negedge clk);
      send(C_ABORT, '0, '0, 0);
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         chk($sformatf("aborted j=%0d {ld,inc,done,busy}", j),
             32'({cnt_ld, cnt_inc, done, busy}), 32'd0);
      end

      // ABORT in the same cycle as the terminal match
      send(C_START, 8'd3, 8'd5, 0);
      for (int off = 1; off <= 3; off++) begin
         @(negedge clk);
         ex = expect_at(off, 2, 0);
         chk($sformatf("pre_abort_term off=%0d", off),
             32'({cnt_ld, cnt_inc, done, busy, cmd_ready}), 32'(ex));
      end
      @(posedge clk);
      #1 cmd_valid = 1'b1;
      cmd_op = C_ABORT;
      @(negedge clk);
      chk("abort_term cnt_q", 32'(cnt_q), 32'd5);
      chk("abort_term inc", 32'(cnt_inc), 32'd0);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         chk($sformatf("after_abort_term j=%0d {done,busy}", j), 32'({done, busy}), 32'd0);
      end

      // Asynchronous reset mid-RUN
      send(C_START, 8'd3, 8'd9, 2);
      repeat (6) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_rst {ld,inc,done,busy,rdy}", 32'({cnt_ld, cnt_inc, done, busy, cmd_ready}), 32'b00001);
      chk("async_rst cnt_v", 32'(cnt_v), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int j = 0; j < 24; j++) begin
         @(negedge clk);
         chk($sformatf("post_rst j=%0d {ld,inc,done,busy}", j),
             32'({cnt_ld, cnt_inc, done, busy}), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
